// File: rtl/multi_clock_divider_if.sv
// ---------------------------------------------------------------------------
// multi_clock_divider_if
//
// Purpose:
//   Bundles the divisor write port, the global sync request and the
//   per-channel divider outputs of multi_clock_divider into one interface.
//
// Signals:
//   io_wrValid    divisor write request
//   io_wrReady    write can be accepted this cycle
//   io_wrChannel  target channel of the write (CW bits)
//   io_wrDivisor  new divisor (WIDTH bits); 0 disables the channel
//   io_syncAll    one-cycle request to restart all channels in phase
//   io_clkOut     divided clock per channel
//   io_tick       one-cycle pulse at each io_clkOut period start
//   io_pending    channel holds an accepted divisor not yet applied
//
// Modports:
//   master  drives requests, observes divider outputs (controller / bench)
//   slave   the divider itself
// ---------------------------------------------------------------------------
interface multi_clock_divider_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
);

  // Channel index width; at least one bit even for a single channel.
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                io_wrValid;
  logic                io_wrReady;
  logic [CW-1:0]       io_wrChannel;
  logic [WIDTH-1:0]    io_wrDivisor;
  logic                io_syncAll;
  logic [CHANNELS-1:0] io_clkOut;
  logic [CHANNELS-1:0] io_tick;
  logic [CHANNELS-1:0] io_pending;

  modport master (
    output io_wrValid,
    output io_wrChannel,
    output io_wrDivisor,
    output io_syncAll,
    input  io_wrReady,
    input  io_clkOut,
    input  io_tick,
    input  io_pending
  );

  modport slave (
    input  io_wrValid,
    input  io_wrChannel,
    input  io_wrDivisor,
    input  io_syncAll,
    output io_wrReady,
    output io_clkOut,
    output io_tick,
    output io_pending
  );

endinterface

// File: rtl/multi_clock_divider.sv
// ---------------------------------------------------------------------------
// multi_clock_divider
//
// Purpose:
//   CHANNELS independent programmable clock dividers. Each channel counts
//   system clock cycles modulo its divisor and produces a registered,
//   roughly 50% duty divided clock (io_clkOut) plus a one-cycle tick at the
//   start of every period (io_tick). Divisors are written through a
//   valid/ready port into a per-channel holding register and only take
//   effect at a period boundary, so the divided clock never glitches.
//   A global sync request restarts every channel in phase.
//
// Ports:
//   clock   system clock, all logic on the rising edge
//   reset   asynchronous active-low reset (release expected synchronous)
//   bus     multi_clock_divider_if.slave:
//             io_wrValid / io_wrReady / io_wrChannel / io_wrDivisor
//               divisor write handshake
//             io_syncAll   restart all channels in phase
//             io_clkOut    divided clock per channel (registered)
//             io_tick      period-start pulse per channel (registered)
//             io_pending   accepted divisor waiting to be applied
// ---------------------------------------------------------------------------
module multi_clock_divider #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 120
) (
  input  logic                   clock,
  input  logic                   reset,
  multi_clock_divider_if.slave   bus
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [WIDTH-1:0] ZERO      = '0;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(DEFAULT_DIV - 1);

  // One-hot decode of the write target. An out-of-range channel index
  // matches no channel, so such a write is accepted and simply dropped.
  logic [CHANNELS-1:0] wr_sel;
  logic [CHANNELS-1:0] pend_all;
  logic [CHANNELS-1:0] clk_out_all;
  logic [CHANNELS-1:0] tick_all;
  logic                wr_fire;

  // A channel can take a new divisor only once the previous one is applied.
  assign bus.io_wrReady = ~|(wr_sel & pend_all);
  assign wr_fire        = bus.io_wrValid & bus.io_wrReady;

  assign bus.io_clkOut  = clk_out_all;
  assign bus.io_tick    = tick_all;
  assign bus.io_pending = pend_all;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch

    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] pend_div_q;
    logic             pend_q;
    logic             clk_out_q;
    logic             tick_q;

    logic [WIDTH-1:0] div_d;
    logic [WIDTH-1:0] cnt_d;
    logic             pend_d;
    logic [WIDTH-1:0] thresh_d;
    logic             disabled;
    logic             wrap;
    logic             apply;
    logic             accept;

    assign wr_sel[g]      = (bus.io_wrChannel == CW'(g));
    assign pend_all[g]    = pend_q;
    assign clk_out_all[g] = clk_out_q;
    assign tick_all[g]    = tick_q;

    assign disabled = (div_q == ZERO);
    assign wrap     = !disabled && (cnt_q == (div_q - ONE));
    assign accept   = wr_fire & wr_sel[g];

    // A pending divisor lands at a period boundary: the wrap edge, any edge
    // while the channel is idle, or a global sync. Acceptance can never
    // coincide with an apply because a pending channel is not ready, which
    // is what keeps a write on a wrap edge waiting for the following wrap.
    assign apply = pend_q & (wrap | disabled | bus.io_syncAll);

    // Next-state for divisor, counter and pending flag.
    always_comb begin
      div_d  = div_q;
      cnt_d  = cnt_q;
      pend_d = pend_q;
      if (apply) begin
        div_d  = pend_div_q;
        cnt_d  = ZERO;
        pend_d = 1'b0;
      end else if (bus.io_syncAll || disabled || wrap) begin
        cnt_d  = ZERO;
      end else begin
        cnt_d  = cnt_q + ONE;
      end
      if (accept) begin
        pend_d = 1'b1;
      end
    end

    // High phase length: half the period, rounded down, except that a
    // divide-by-one channel is permanently high.
    assign thresh_d = (div_d == ONE) ? ONE : (div_d >> 1);

    // State and registered outputs. Outputs are computed from the next
    // state so they line up with the counter value held after this edge.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        div_q      <= RESET_DIV;
        cnt_q      <= RESET_CNT;
        pend_q     <= 1'b0;
        pend_div_q <= ZERO;
        clk_out_q  <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        div_q      <= div_d;
        cnt_q      <= cnt_d;
        pend_q     <= pend_d;
        if (accept) begin
          pend_div_q <= bus.io_wrDivisor;
        end
        clk_out_q  <= (div_d != ZERO) && (cnt_d < thresh_d);
        tick_q     <= (div_d != ZERO) && (cnt_d == ZERO);
      end
    end

  end : g_ch

endmodule

// File: tb/tb_multi_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_multi_clock_divider
//
// Self-checking bench for multi_clock_divider. A four-channel instance is
// checked cycle by cycle against a spec-level reference model through a
// scoreboard queue; a three-channel instance covers the out-of-range write.
// ---------------------------------------------------------------------------
module tb_multi_clock_divider;

  localparam int CH   = 4;
  localparam int W    = 16;
  localparam int DDIV = 120;

  typedef struct packed {
    logic [CH-1:0] tick;
    logic [CH-1:0] clk;
    logic [CH-1:0] pend;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  // reference model state
  int m_div [CH];
  int m_cnt [CH];
  int m_pdiv[CH];
  bit m_pend[CH];

  always #5 clock = ~clock;

  multi_clock_divider_if #(.CHANNELS(CH), .WIDTH(W)) bus ();
  multi_clock_divider_if #(.CHANNELS(3),  .WIDTH(W)) bus3 ();

  multi_clock_divider #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DDIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  multi_clock_divider #(.CHANNELS(3), .WIDTH(W), .DEFAULT_DIV(DDIV)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3)
  );

  // reference model: state after reset
  task automatic model_init();
    for (int i = 0; i < CH; i++) begin
      m_div[i]  = DDIV;
      m_cnt[i]  = DDIV - 1;
      m_pdiv[i] = 0;
      m_pend[i] = 1'b0;
    end
    sb.delete();
  endtask

  function automatic bit model_ready(input int ch);
    return (ch >= CH) ? 1'b1 : !m_pend[ch];
  endfunction

  // reference model: one rising edge with the given inputs; pushes the
  // outputs expected to be visible after that edge
  task automatic model_edge(input bit v, input int ch, input int d, input bit s);
    exp_t e;
    bit   acc;
    bit   at_wrap;
    int   hi;
    acc = v && model_ready(ch);
    for (int i = 0; i < CH; i++) begin
      at_wrap = (m_div[i] != 0) && (m_cnt[i] == m_div[i] - 1);
      if (m_pend[i] && (at_wrap || m_div[i] == 0 || s)) begin
        m_div[i]  = m_pdiv[i];
        m_cnt[i]  = 0;
        m_pend[i] = 1'b0;
      end else if (s || at_wrap || m_div[i] == 0) begin
        m_cnt[i] = 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
    if (acc && ch < CH) begin
      m_pend[ch] = 1'b1;
      m_pdiv[ch] = d;
    end
    for (int i = 0; i < CH; i++) begin
      hi        = (m_div[i] == 1) ? 1 : m_div[i] / 2;
      e.tick[i] = (m_div[i] != 0) && (m_cnt[i] == 0);
      e.clk[i]  = (m_div[i] != 0) && (m_cnt[i] < hi);
      e.pend[i] = m_pend[i];
    end
    sb.push_back(e);
  endtask

  task automatic drive(input bit v, input int ch, input int d, input bit s);
    bus.io_wrValid   = v;
    bus.io_wrChannel = 2'(ch);
    bus.io_wrDivisor = W'(d);
    bus.io_syncAll   = s;
  endtask

  task automatic apply_reset();
    drive(1'b0, 0, 0, 1'b0);
    bus3.io_wrValid   = 1'b0;
    bus3.io_wrChannel = '0;
    bus3.io_wrDivisor = '0;
    bus3.io_syncAll   = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    model_init();
  endtask

  // reset values, then default divide-by-120 behaviour on closed-form timing
  task automatic test_reset();
    exp_t e;
    int   c;
    int   hi0;
    int   tk0;
    drive(1'b0, 0, 0, 1'b0);
    bus3.io_wrValid   = 1'b0;
    bus3.io_wrChannel = '0;
    bus3.io_wrDivisor = '0;
    bus3.io_syncAll   = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({bus.io_tick, bus.io_clkOut, bus.io_pending} !== 12'h000) begin
        n_bad++;
        $display("[TB] FAIL reset_outputs cyc=%0d got %h want 000", i,
                 {bus.io_tick, bus.io_clkOut, bus.io_pending});
      end
      n_cmp++;
      if (bus.io_wrReady !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL reset_ready cyc=%0d got %b want 1", i, bus.io_wrReady);
      end
    end
    reset = 1'b1;
    for (int k = 1; k <= 250; k++) begin
      c      = (k - 1) % DDIV;
      e.tick = (c == 0) ? 4'hF : 4'h0;
      e.clk  = (c < DDIV / 2) ? 4'hF : 4'h0;
      e.pend = 4'h0;
      sb.push_back(e);
    end
    hi0 = 0;
    tk0 = 0;
    for (int k = 1; k <= 250; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.io_tick, bus.io_clkOut, bus.io_pending} !== e) begin
        n_bad++;
        $display("[TB] FAIL default_run k=%0d got tick/clk/pend=%b/%b/%b want %b/%b/%b",
                 k, bus.io_tick, bus.io_clkOut, bus.io_pending, e.tick, e.clk, e.pend);
      end
      if (k <= 120 && bus.io_clkOut[0]) hi0++;
      if (bus.io_tick[0]) tk0++;
    end
    n_cmp++;
    if (hi0 !== 60) begin
      n_bad++;
      $display("[TB] FAIL default_high_count got %0d want 60", hi0);
    end
    n_cmp++;
    if (tk0 !== 3) begin
      n_bad++;
      $display("[TB] FAIL default_tick_count got %0d want 3", tk0);
    end
  endtask

  // write 10 to ch1 at cnt=30; applies at the wrap, then period 10
  task automatic test_reprogram();
    exp_t e;
    bit v, s;
    int ch, d, tk1, hi1, tk0;
    apply_reset();
    tk1 = 0; hi1 = 0; tk0 = 0;
    for (int k = 1; k <= 170; k++) begin
      v = 0; ch = 0; d = 0; s = 0;
      if (k == 32) begin v = 1; ch = 1; d = 10; end
      if (k == 33) ch = 1;
      drive(v, ch, d, s);
      #1;
      n_cmp++;
      if (bus.io_wrReady !== model_ready(ch)) begin
        n_bad++;
        $display("[TB] FAIL reprogram_ready k=%0d got %b want %b", k, bus.io_wrReady, model_ready(ch));
      end
      if (k == 33) begin
        n_cmp++;
        if (bus.io_wrReady !== 1'b0) begin
          n_bad++;
          $display("[TB] FAIL reprogram_busy k=%0d got %b want 0", k, bus.io_wrReady);
        end
      end
      model_edge(v, ch, d, s);
      @(negedge clock);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.io_tick, bus.io_clkOut, bus.io_pending} !== e) begin
        n_bad++;
        $display("[TB] FAIL reprogram_run k=%0d got tick/clk/pend=%b/%b/%b want %b/%b/%b",
                 k, bus.io_tick, bus.io_clkOut, bus.io_pending, e.tick, e.clk, e.pend);
      end
      if (k >= 121 && k <= 160) begin
        if (bus.io_tick[1]) tk1++;
        if (bus.io_clkOut[1]) hi1++;
      end
      if (bus.io_tick[0]) tk0++;
    end
    n_cmp++;
    if (tk1 !== 4 || hi1 !== 20) begin
      n_bad++;
      $display("[TB] FAIL reprogram_period got ticks=%0d high=%0d want 4/20", tk1, hi1);
    end
    n_cmp++;
    if (tk0 !== 2) begin
      n_bad++;
      $display("[TB] FAIL reprogram_ch0_ticks got %0d want 2", tk0);
    end
  endtask

  // divisor 3 on ch2, divisor 1 on ch3
  task automatic test_odd_unit();
    exp_t e;
    bit v, s;
    int ch, d, tk2, hi3;
    apply_reset();
    tk2 = 0; hi3 = 0;
    for (int k = 1; k <= 160; k++) begin
      v = 0; ch = 0; d = 0; s = 0;
      if (k == 2) begin v = 1; ch = 2; d = 3; end
      if (k == 3) begin v = 1; ch = 3; d = 1; end
      drive(v, ch, d, s);
      #1;
      n_cmp++;
      if (bus.io_wrReady !== model_ready(ch)) begin
        n_bad++;
        $display("[TB] FAIL odd_ready k=%0d got %b want %b", k, bus.io_wrReady, model_ready(ch));
      end
      model_edge(v, ch, d, s);
      @(negedge clock);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.io_tick, bus.io_clkOut, bus.io_pending} !== e) begin
        n_bad++;
        $display("[TB] FAIL odd_run k=%0d got tick/clk/pend=%b/%b/%b want %b/%b/%b",
                 k, bus.io_tick, bus.io_clkOut, bus.io_pending, e.tick, e.clk, e.pend);
      end
      if (k >= 121 && k <= 159 && bus.io_tick[2]) tk2++;
      if (k >= 122 && bus.io_clkOut[3] && bus.io_tick[3]) hi3++;
    end
    n_cmp++;
    if (tk2 !== 13) begin
      n_bad++;
      $display("[TB] FAIL odd_div3_ticks got %0d want 13", tk2);
    end
    n_cmp++;
    if (hi3 !== 39) begin
      n_bad++;
      $display("[TB] FAIL odd_div1_cycles got %0d want 39", hi3);
    end
  endtask

  // disable ch0, then re-enable with divisor 4
  task automatic test_disable_enable();
    exp_t e;
    bit v, s;
    int ch, d, tk_off, tk_on, hi_on;
    apply_reset();
    tk_off = 0; tk_on = 0; hi_on = 0;
    for (int k = 1; k <= 150; k++) begin
      v = 0; ch = 0; d = 0; s = 0;
      if (k == 2)   begin v = 1; ch = 0; d = 0; end
      if (k == 130) begin v = 1; ch = 0; d = 4; end
      drive(v, ch, d, s);
      #1;
      n_cmp++;
      if (bus.io_wrReady !== model_ready(ch)) begin
        n_bad++;
        $display("[TB] FAIL disable_ready k=%0d got %b want %b", k, bus.io_wrReady, model_ready(ch));
      end
      model_edge(v, ch, d, s);
      @(negedge clock);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.io_tick, bus.io_clkOut, bus.io_pending} !== e) begin
        n_bad++;
        $display("[TB] FAIL disable_run k=%0d got tick/clk/pend=%b/%b/%b want %b/%b/%b",
                 k, bus.io_tick, bus.io_clkOut, bus.io_pending, e.tick, e.clk, e.pend);
      end
      if (k >= 121 && k <= 130 && (bus.io_tick[0] || bus.io_clkOut[0])) tk_off++;
      if (k >= 131) begin
        if (bus.io_tick[0]) tk_on++;
        if (bus.io_clkOut[0]) hi_on++;
      end
    end
    n_cmp++;
    if (tk_off !== 0) begin
      n_bad++;
      $display("[TB] FAIL disabled_activity got %0d want 0", tk_off);
    end
    n_cmp++;
    if (tk_on !== 5 || hi_on !== 10) begin
      n_bad++;
      $display("[TB] FAIL enable_div4 got ticks=%0d high=%0d want 5/10", tk_on, hi_on);
    end
  endtask

  // sync with a pending write on ch0 and a write to ch1 in the sync cycle
  task automatic test_sync();
    exp_t e;
    bit v, s;
    int ch, d, tk0, tk1;
    apply_reset();
    tk0 = 0; tk1 = 0;
    for (int k = 1; k <= 120; k++) begin
      v = 0; ch = 0; d = 0; s = 0;
      if (k == 2)  begin v = 1; ch = 1; d = 10; end
      if (k == 3)  begin v = 1; ch = 2; d = 3;  end
      if (k == 4)  begin v = 1; ch = 3; d = 7;  end
      if (k == 6)  s = 1;
      if (k == 20) begin v = 1; ch = 0; d = 50; end
      if (k == 40) begin v = 1; ch = 1; d = 20; s = 1; end
      drive(v, ch, d, s);
      #1;
      n_cmp++;
      if (bus.io_wrReady !== model_ready(ch)) begin
        n_bad++;
        $display("[TB] FAIL sync_ready k=%0d got %b want %b", k, bus.io_wrReady, model_ready(ch));
      end
      model_edge(v, ch, d, s);
      @(negedge clock);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.io_tick, bus.io_clkOut, bus.io_pending} !== e) begin
        n_bad++;
        $display("[TB] FAIL sync_run k=%0d got tick/clk/pend=%b/%b/%b want %b/%b/%b",
                 k, bus.io_tick, bus.io_clkOut, bus.io_pending, e.tick, e.clk, e.pend);
      end
      if (k == 40) begin
        n_cmp++;
        if (bus.io_tick !== 4'b1111 || bus.io_pending !== 4'b0010) begin
          n_bad++;
          $display("[TB] FAIL sync_pulse got tick=%b pend=%b want 1111/0010",
                   bus.io_tick, bus.io_pending);
        end
      end
      if (k >= 40) begin
        if (bus.io_tick[0]) tk0++;
        if (bus.io_tick[1]) tk1++;
      end
    end
    n_cmp++;
    if (tk0 !== 2 || tk1 !== 5) begin
      n_bad++;
      $display("[TB] FAIL sync_periods got ch0=%0d ch1=%0d want 2/5", tk0, tk1);
    end
  endtask

  // reset asserted between edges with a pending write, then default restart
  task automatic test_async_reset();
    exp_t e;
    bit v, s;
    int ch, d;
    apply_reset();
    for (int k = 1; k <= 20; k++) begin
      v = 0; ch = 0; d = 0; s = 0;
      if (k == 2) begin v = 1; ch = 3; d = 1;  end
      if (k == 3) s = 1;
      if (k == 5) begin v = 1; ch = 1; d = 10; end
      drive(v, ch, d, s);
      model_edge(v, ch, d, s);
      @(negedge clock);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.io_tick, bus.io_clkOut, bus.io_pending} !== e) begin
        n_bad++;
        $display("[TB] FAIL prereset_run k=%0d got tick/clk/pend=%b/%b/%b want %b/%b/%b",
                 k, bus.io_tick, bus.io_clkOut, bus.io_pending, e.tick, e.clk, e.pend);
      end
    end
    n_cmp++;
    if (bus.io_pending !== 4'b0010 || bus.io_clkOut[3] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL prereset_state got pend=%b clk3=%b want 0010/1",
               bus.io_pending, bus.io_clkOut[3]);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.io_tick, bus.io_clkOut, bus.io_pending} !== 12'h000) begin
      n_bad++;
      $display("[TB] FAIL async_reset got %h want 000", {bus.io_tick, bus.io_clkOut, bus.io_pending});
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    model_init();
    for (int k = 1; k <= 130; k++) begin
      drive(1'b0, 0, 0, 1'b0);
      model_edge(1'b0, 0, 0, 1'b0);
      @(negedge clock);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.io_tick, bus.io_clkOut, bus.io_pending} !== e) begin
        n_bad++;
        $display("[TB] FAIL postreset_run k=%0d got tick/clk/pend=%b/%b/%b want %b/%b/%b",
                 k, bus.io_tick, bus.io_clkOut, bus.io_pending, e.tick, e.clk, e.pend);
      end
    end
  endtask

  // three-channel instance: write to channel 3 is accepted and ignored
  task automatic test_out_of_range();
    logic [2:0] want_tick;
    apply_reset();
    for (int k = 1; k <= 130; k++) begin
      bus3.io_wrValid   = (k == 3);
      bus3.io_wrChannel = 2'd3;
      bus3.io_wrDivisor = W'(5);
      #1;
      if (k == 3) begin
        n_cmp++;
        if (bus3.io_wrReady !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL oor_ready got %b want 1", bus3.io_wrReady);
        end
      end
      @(negedge clock);
      want_tick = (((k - 1) % DDIV) == 0) ? 3'b111 : 3'b000;
      n_cmp++;
      if (bus3.io_pending !== 3'b000 || bus3.io_tick !== want_tick) begin
        n_bad++;
        $display("[TB] FAIL oor_run k=%0d got pend=%b tick=%b want 000/%b",
                 k, bus3.io_pending, bus3.io_tick, want_tick);
      end
    end
    bus3.io_wrValid = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_reprogram();
    test_odd_unit();
    test_disable_enable();
    test_sync();
    test_async_reset();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
